// File: rtl/pump_seq_pkg.sv
// pump_seq_pkg: shared state/owner types and duty width for the pump sequencer
package pump_seq_pkg;
    localparam int DUTY_W = 8;
    typedef enum logic [2:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN, DEAD} state_t;
    typedef enum logic {PUMP_A, PUMP_B} owner_t;
endpackage

// File: rtl/pump_sequencer_duty_slew.sv
// duty_slew: moves a duty value one STEP toward a target, clamped so it never overshoots or wraps
module duty_slew
    import pump_seq_pkg::*;
#(
    parameter int STEP = 16
) (
    input  logic [DUTY_W-1:0] cur,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] next
);
    logic [DUTY_W-1:0] step;
    assign step = DUTY_W'(STEP);
    // distance is taken in the direction of travel, so the clamp also prevents 8-bit wrap
    always_comb begin
        next = (cur < target) ? ((target - cur > step) ? cur + step : target)
                              : ((cur - target > step) ? cur - step : target);
    end
endmodule

// File: rtl/pump_sequencer.sv
// pump_sequencer: two-pump owner arbitration with ramped duty and dead time; PUMP_SEQ_YIELD_EN adds the fairness yield
module pump_sequencer
    import pump_seq_pkg::*;
#(
    parameter int STEP             = 16,
    parameter int RAMP_STEP_CYCLES = 4,
    parameter int DEAD_CYCLES      = 8,
    parameter int MAX_RUN_CYCLES   = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] req_duty_a,
    input  logic [DUTY_W-1:0] req_duty_b,
    input  logic              enable,
    output logic [DUTY_W-1:0] duty_a,
    output logic [DUTY_W-1:0] duty_b,
    output logic              grant_a,
    output logic              grant_b,
    output logic              busy
);
    localparam int CNT_MAX = (RAMP_STEP_CYCLES > DEAD_CYCLES) ? RAMP_STEP_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    state_t            state, state_nxt;
    owner_t            owner, owner_nxt, last, last_nxt;
    logic [DUTY_W-1:0] duty, duty_nxt, target, slew;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              active, tick, own_req, yield;
    assign active  = state == RAMP_UP || state == RUN || state == RAMP_DOWN;
    assign tick    = active && cnt == CNT_W'(RAMP_STEP_CYCLES - 1);
    assign own_req = (owner == PUMP_A) ? |req_duty_a : |req_duty_b;
    assign target  = (state == RAMP_DOWN) ? '0 : ((owner == PUMP_A) ? req_duty_a : req_duty_b);
    duty_slew #(.STEP(STEP)) u_slew (
        .cur    (duty),
        .target (target),
        .next   (slew)
    );
`ifdef PUMP_SEQ_YIELD_EN
    localparam int RUN_W = $clog2(MAX_RUN_CYCLES + 1);
    logic [RUN_W-1:0] run_cnt;
    logic             other_req;
    assign other_req = (owner == PUMP_A) ? |req_duty_b : |req_duty_a;
    // ownership age: cleared while idle, counts RAMP_UP/RUN cycles and saturates at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) run_cnt <= '0;
        else if (state == IDLE) run_cnt <= '0;
        else if ((state == RAMP_UP || state == RUN) && run_cnt != RUN_W'(MAX_RUN_CYCLES)) run_cnt <= run_cnt + 1'b1;
    end
    assign yield = run_cnt == RUN_W'(MAX_RUN_CYCLES) && other_req;
`else
    assign yield = MAX_RUN_CYCLES < 1;
`endif
    // state, owner, last-served pointer, owner duty and shared tick/dead counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= PUMP_A;
            last  <= PUMP_B;
            duty  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            duty  <= duty_nxt;
            cnt   <= cnt_nxt;
        end
    end
    // next-state: arbitration in IDLE, slewing while owned, timed dead gap before re-arbitration
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        duty_nxt  = duty;
        cnt_nxt   = (state == IDLE || tick) ? '0 : cnt + 1'b1;
        case (state)
            IDLE: if (enable && (|req_duty_a || |req_duty_b)) begin
                owner_nxt = (|req_duty_a && |req_duty_b) ? ((last == PUMP_A) ? PUMP_B : PUMP_A)
                                                         : (|req_duty_a ? PUMP_A : PUMP_B);
                last_nxt  = owner_nxt;
                duty_nxt  = '0;
                state_nxt = RAMP_UP;
            end
            RAMP_UP, RUN: if (!own_req || !enable || yield) state_nxt = RAMP_DOWN;
            else begin
                if (tick) duty_nxt = slew;
                if (state == RAMP_UP && duty == target) state_nxt = RUN;
            end
            RAMP_DOWN: if (duty == '0 || (tick && slew == '0)) begin
                duty_nxt  = '0;
                state_nxt = DEAD;
            end else if (tick) duty_nxt = slew;
            DEAD: if (cnt == CNT_W'(DEAD_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end
    assign grant_a = active && owner == PUMP_A;
    assign grant_b = active && owner == PUMP_B;
    assign duty_a  = grant_a ? duty : '0;
    assign duty_b  = grant_b ? duty : '0;
    assign busy    = state != IDLE;
endmodule
